bicubic_pixel_serializer: RTL and testbench



---
 rtl/bicubic_pixel_serializer.sv | 143 ++++++++++++++
 tb/tb_bicubic_pixel_serializer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/bicubic_pixel_serializer.sv
// Serializes 4-pixel bicubic response beats into a one-pixel-per-cycle raster stream with SOF/EOL/EOF markers.
// Optional build macro BICUBIC_SER_FRAME_CNT_EN adds a 16-bit completed-frame counter output.
module bicubic_pixel_serializer #(
   parameter int CHANNEL_WIDTH = 8,
   parameter int BLOCK_SIZE    = 960,
   parameter int OUT_ROWS      = 2160
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     bcci_rsp_valid,
   input  logic [CHANNEL_WIDTH-1:0] bcci_rsp_data1,
   input  logic [CHANNEL_WIDTH-1:0] bcci_rsp_data2,
   input  logic [CHANNEL_WIDTH-1:0] bcci_rsp_data3,
   input  logic [CHANNEL_WIDTH-1:0] bcci_rsp_data4,
   output logic                     bf_rsp_ready,
   output logic                     ser_valid,
   output logic [CHANNEL_WIDTH-1:0] ser_data,
   output logic                     ser_sof,
   output logic                     ser_eol,
   output logic                     ser_eof,
   input  logic                     ser_ready
`ifdef BICUBIC_SER_FRAME_CNT_EN
   ,
   output logic [15:0]              frame_cnt
`endif
);

   localparam int ROW_PIX = BLOCK_SIZE * 4;
   localparam int COL_W   = (ROW_PIX > 1) ? $clog2(ROW_PIX) : 1;
   localparam int ROW_W   = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(ROW_PIX - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(OUT_ROWS - 1);

   typedef enum logic {
      ST_EMPTY,
      ST_FULL
   } state_t;

   state_t                   state;
   state_t                   state_nxt;
   logic [1:0]               idx;
   logic [1:0]               idx_nxt;
   logic [CHANNEL_WIDTH-1:0] slot [4];
   logic [COL_W-1:0]         col;
   logic [COL_W-1:0]         col_nxt;
   logic [ROW_W-1:0]         row;
   logic [ROW_W-1:0]         row_nxt;
   logic                     full;
   logic                     last_pix;
   logic                     pix_hs;
   logic                     beat_hs;

   // Ready opens while the final pixel leaves so back-to-back beats have no bubble.
   always_comb begin
      full         = (state == ST_FULL);
      last_pix     = full && (idx == 2'd3);
      pix_hs       = full && ser_ready;
      bf_rsp_ready = !full || (last_pix && ser_ready);
      beat_hs      = bcci_rsp_valid && bf_rsp_ready;
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      if (beat_hs) begin
         state_nxt = ST_FULL;
         idx_nxt   = 2'd0;
      end else if (pix_hs) begin
         if (last_pix) begin
            state_nxt = ST_EMPTY;
            idx_nxt   = 2'd0;
         end else begin
            idx_nxt = idx + 2'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_EMPTY;
         idx   <= 2'd0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < 4; i++) begin
            slot[i] <= '0;
         end
      end else if (beat_hs) begin
         slot[0] <= bcci_rsp_data1;
         slot[1] <= bcci_rsp_data2;
         slot[2] <= bcci_rsp_data3;
         slot[3] <= bcci_rsp_data4;
      end
   end

   always_comb begin
      col_nxt = col;
      row_nxt = row;
      if (pix_hs) begin
         if (col == COL_LAST) begin
            col_nxt = '0;
            row_nxt = (row == ROW_LAST) ? '0 : row + ROW_W'(1);
         end else begin
            col_nxt = col + COL_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col <= '0;
         row <= '0;
      end else begin
         col <= col_nxt;
         row <= row_nxt;
      end
   end

   // Markers and data are forced to zero whenever no pixel is presented.
   always_comb begin
      ser_valid = full;
      ser_data  = full ? slot[idx] : '0;
      ser_sof   = full && (row == '0) && (col == '0);
      ser_eol   = full && (col == COL_LAST);
      ser_eof   = ser_eol && (row == ROW_LAST);
   end

`ifdef BICUBIC_SER_FRAME_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cnt <= '0;
      end else if (pix_hs && ser_eof) begin
         frame_cnt <= frame_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_bicubic_pixel_serializer.sv
// Self-checking bench for bicubic_pixel_serializer: directed phases plus randomized traffic against a queue model.
module tb_bicubic_pixel_serializer;

   localparam int CW = 8;
   localparam int BS = 2;
   localparam int NR = 3;
   localparam int RP = BS * 4;
   localparam int FP = RP * NR;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          bcci_rsp_valid = 1'b0;
   logic [CW-1:0] bcci_rsp_data1 = '0;
   logic [CW-1:0] bcci_rsp_data2 = '0;
   logic [CW-1:0] bcci_rsp_data3 = '0;
   logic [CW-1:0] bcci_rsp_data4 = '0;
   logic          bf_rsp_ready;
   logic          ser_valid;
   logic [CW-1:0] ser_data;
   logic          ser_sof;
   logic          ser_eol;
   logic          ser_eof;
   logic          ser_ready = 1'b1;
`ifdef BICUBIC_SER_FRAME_CNT_EN
   logic [15:0]   frame_cnt;
`endif

   always #5 clk = ~clk;

   bicubic_pixel_serializer #(
      .CHANNEL_WIDTH(CW),
      .BLOCK_SIZE   (BS),
      .OUT_ROWS     (NR)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .bcci_rsp_valid(bcci_rsp_valid),
      .bcci_rsp_data1(bcci_rsp_data1),
      .bcci_rsp_data2(bcci_rsp_data2),
      .bcci_rsp_data3(bcci_rsp_data3),
      .bcci_rsp_data4(bcci_rsp_data4),
      .bf_rsp_ready  (bf_rsp_ready),
      .ser_valid     (ser_valid),
      .ser_data      (ser_data),
      .ser_sof       (ser_sof),
      .ser_eol       (ser_eol),
      .ser_eof       (ser_eof),
      .ser_ready     (ser_ready)
`ifdef BICUBIC_SER_FRAME_CNT_EN
      ,
      .frame_cnt     (frame_cnt)
`endif
   );

   int            checks = 0;
   int            errors = 0;
   logic [CW-1:0] q [$];
   int            k = 0;
   int            fcnt = 0;
   logic [CW-1:0] src_d [4];
   int            seq_val = 1;
   bit            rand_data = 1'b0;

   task automatic chk1(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic new_beat();
      for (int i = 0; i < 4; i++) begin
         if (rand_data) begin
            src_d[i] = CW'($urandom);
         end else begin
            src_d[i] = CW'(seq_val);
            seq_val++;
         end
      end
   endtask

   // One clock cycle: drive, check the model's prediction, then advance the model at the edge.
   task automatic cycle(input bit v, input bit rdy, input bit r, input bit chk);
      bit            exp_valid;
      bit            exp_ready;
      bit            ph;
      bit            bh;
      logic [CW-1:0] exp_data;
      bcci_rsp_valid = v;
      bcci_rsp_data1 = src_d[0];
      bcci_rsp_data2 = src_d[1];
      bcci_rsp_data3 = src_d[2];
      bcci_rsp_data4 = src_d[3];
      ser_ready      = rdy;
      rst            = r;
      #4;
      exp_valid = (q.size() > 0);
      exp_ready = (q.size() == 0) || (q.size() == 1 && rdy);
      exp_data  = '0;
      if (exp_valid) exp_data = q[0];
      if (chk) begin
         chk1("ser_valid", 16'(ser_valid), 16'(exp_valid));
         chk1("ser_data", 16'(ser_data), 16'(exp_data));
         chk1("ser_sof", 16'(ser_sof), 16'(exp_valid && k == 0));
         chk1("ser_eol", 16'(ser_eol), 16'(exp_valid && (k % RP) == RP - 1));
         chk1("ser_eof", 16'(ser_eof), 16'(exp_valid && k == FP - 1));
         chk1("bf_rsp_ready", 16'(bf_rsp_ready), 16'(exp_ready));
`ifdef BICUBIC_SER_FRAME_CNT_EN
         chk1("frame_cnt", frame_cnt, 16'(fcnt));
`endif
      end
      ph = !r && exp_valid && rdy;
      bh = !r && v && exp_ready;
      @(posedge clk);
      if (r) begin
         q.delete();
         k    = 0;
         fcnt = 0;
      end else begin
         if (ph) begin
            if (k == FP - 1) fcnt = (fcnt + 1) & 16'hFFFF;
            void'(q.pop_front());
            k = (k + 1) % FP;
         end
         if (bh) begin
            for (int i = 0; i < 4; i++) q.push_back(src_d[i]);
            new_beat();
         end
      end
      #1;
   endtask

   initial begin
      new_beat();
      @(posedge clk);
      #1;
      // reset state
      cycle(1'b0, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b1, 1'b1);
      cycle(1'b0, 1'b1, 1'b1, 1'b1);

      // continuous beats 1..24 and beyond, no backpressure
      repeat (FP + 2) cycle(1'b1, 1'b1, 1'b0, 1'b1);

      // backpressure while third pixel of a beat is presented
      for (int i = 0; i < 8 && q.size() != 2; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1);
      repeat (5) cycle(1'b1, 1'b0, 1'b0, 1'b1);
      repeat (6) cycle(1'b1, 1'b1, 1'b0, 1'b1);

      // upstream gap after a beat drains
      for (int i = 0; i < 8 && q.size() != 0; i++) cycle(1'b0, 1'b1, 1'b0, 1'b1);
      repeat (3) cycle(1'b0, 1'b1, 1'b0, 1'b1);
      repeat (8) cycle(1'b1, 1'b1, 1'b0, 1'b1);

      // reset while pixel 13 of the frame is presented
      for (int i = 0; i < 3 * FP && k != 12; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1);
      cycle(1'b0, 1'b1, 1'b1, 1'b1);
      repeat (10) cycle(1'b1, 1'b1, 1'b0, 1'b1);

      // randomized traffic and data
      rand_data = 1'b1;
      for (int i = 0; i < 600; i++) begin
         cycle(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 250) == 0, 1'b1);
      end

      // two full frames from the origin
      rand_data = 1'b0;
      cycle(1'b0, 1'b1, 1'b1, 1'b1);
      repeat (2 * FP + 8) cycle(1'b1, 1'b1, 1'b0, 1'b1);
      cycle(1'b0, 1'b1, 1'b0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
